lsu_master: RTL and testbench
=============================

# lsu_master

Load/store initiator for the MEM stage. It turns pipeline load/store requests (word, halfword, byte) into word-wide read/write transactions toward a word-addressed data memory over a req/ack handshake. Halfword and byte stores use read-modify-write; loads are extracted and sign- or zero-extended. The pipeline stalls while a transaction is in flight.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a load/store this cycle
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SH/SB
- req_pc  in  32  PC of the request, used for the trace only
- stall  out  1  pipeline must hold MEM-stage inputs stable
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- addr_err  out  1  valid with resp_valid: misaligned access
- mem_req  out  1  transaction request to memory
- mem_we  out  1  1 write, 0 read
- mem_addr  out  32  word address: {req_addr[31:2],2'b00}
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read word, valid when mem_ack=1
- mem_ack  in  1  memory completes the current transaction this cycle

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, req_valid=1: latch op, addr, wdata and pc.
  - Misaligned access goes to DONE with addr_err. LW/SW are misaligned if addr[1:0]!=0; LH/LHU/SH if addr[0]!=0.
  - Otherwise SW goes to WR; every other op goes to RD.
- RD: mem_req=1, mem_we=0. On mem_ack:
  - Loads: capture the extracted data and go to DONE.
  - SH/SB: merge store data into mem_rdata and go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = full word (SW) or merged word. On mem_ack, go to DONE.
- DONE: resp_valid=1 for one cycle, then go to IDLE.
- Lane selection is little-endian:
  - Byte k = bits [8k+7:8k] with k=addr[1:0].
  - Halfword uses bits [15:0] if addr[1]=0, else [31:16].
- LH/LB sign-extend; LHU/LBU zero-extend.
- stall = (state==IDLE && req_valid) || state==RD || state==WR. stall=0 in DONE so the pipeline advances.
- mem_ack is ignored in IDLE and DONE.
- mem_addr and mem_wdata are held stable while mem_req=1.

## Timing
- Reset values: state IDLE, stall 0, resp_valid 0, resp_rdata 0, addr_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset is asynchronous and takes effect immediately, including mid-transaction. mem_req drops at once, and a late mem_ack after reset is ignored.
- Latency with ack on the first request cycle:
  - Loads and SW: 3 cycles (accept, access, DONE).
  - SH/SB: 4 cycles (accept, RD, WR, DONE).
  - Misaligned: 2 cycles (accept, DONE).
- Each extra cycle mem_ack stays low adds one cycle of stall.
- mem_req is registered and first goes high in the cycle after acceptance.
- Back-to-back requests: a new request may be accepted in the IDLE cycle right after DONE. Throughput is at most one access per 3 cycles.

## Configuration
- LSU_DISPLAY_EN defined: every completed write (WR with mem_ack) prints `"%d@%h: *%h <= %h"` with $time, latched pc, byte address, and the full written word.
  - SH/SB print the merged word at the word-aligned address.
- LSU_DISPLAY_EN undefined: no trace output. Functionally identical.

## Structure
- Package lsu_pkg holds:
  - the op encodings (OP_LW..OP_SB);
  - the state encoding (ST_IDLE, ST_RD, ST_WR, ST_DONE);
  - the misalignment predicate as a constant function.
- Sub-module lsu_lane_mux is purely combinational. It takes op, addr[1:0], wdata and rdata, and produces the extended load value and the merged store word. The FSM stays in lsu_master.

## Test plan
- Reset low mid-RD with mem_req=1 -> mem_req=0 and stall=0 at once. An ack after reset is released produces no resp_valid.
- SW addr 0x10, data 0xDEADBEEF, ack on first request cycle -> one write of 0xDEADBEEF to mem_addr 0x10. resp_valid in cycle 3, stall high cycles 1-2.
- Memory word 0x11223344. SB addr 0x12, data 0xAA -> read then write of 0x11AA3344. Same word, SH addr 0x12, data 0xBEEF -> write 0xBEEF3344.
- Memory word 0x80FF7F01. Expected loads:
  - LB addr 0x2 -> 0xFFFFFFFF
  - LBU addr 0x2 -> 0x000000FF
  - LH addr 0x2 -> 0xFFFF80FF
  - LHU addr 0x0 -> 0x00007F01
- LW addr 0x6 -> addr_err=1, resp_valid in cycle 2, mem_req never asserted. SH addr 0x3 -> same.
- LW with mem_ack delayed 4 cycles -> stall holds 5 cycles and mem_addr stays stable. resp_rdata equals mem_rdata at the ack cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: op and state encodings plus access-classification helpers
// shared by the load/store initiator and its lane mux.
package lsu_pkg;

  // Pipeline load/store op encodings.
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // Initiator FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_master_if.sv
// lsu_master_if: word-wide req/ack data-memory bus between the load/store
// initiator (master) and the data memory (slave).
interface lsu_master_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: little-endian lane selection. Produces the sign/zero
// extended load value and the store word merged into the read word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, extend it for loads and splice it in for stores.
  always_comb begin
    // NOTE: every output is given a value before the case statements so no
    // path leaves it unassigned and no latch is inferred.
    byte_sel    = rdata[7:0];
    half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data   = rdata;
    merged_word = rdata;

    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    case (op)
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = rdata;
    endcase

    case (op)
      OP_SW: merged_word = wdata;
      OP_SH: begin
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      OP_SB: begin
        case (addr_lo)
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          2'd3:    merged_word[31:24] = wdata[7:0];
          default: merged_word[7:0]   = wdata[7:0];
        endcase
      end
      default: merged_word = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: MEM-stage load/store initiator. Converts word/half/byte
// loads and stores into word transactions on a req/ack memory bus, using
// read-modify-write for SH/SB. Optional write trace: define LSU_DISPLAY_EN.
module lsu_master
  import lsu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [2:0]   req_op,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [31:0]  req_pc,
  output logic         stall,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         addr_err,
  lsu_master_if.master mem
);

  logic [1:0]  state_q,     state_d;
  logic [2:0]  op_q,        op_d;
  logic [1:0]  addr_lo_q,   addr_lo_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] rdata_q,     rdata_d;
  logic        err_q,       err_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  // mem_wdata_q holds the raw store data until an SH/SB read returns, so it
  // doubles as the store operand for the merge.
  lsu_lane_mux u_lane_mux (
    .op          (op_q),
    .addr_lo     (addr_lo_q),
    .wdata       (mem_wdata_q),
    .rdata       (mem.mem_rdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Next-state and bus-request logic; bus outputs are registered so they
  // stay stable for the whole time mem_req is high.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    pc_d        = pc_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          addr_lo_d   = req_addr[1:0];
          pc_d        = req_pc;
          rdata_d     = 32'h0;
          err_d       = is_misaligned(req_op, req_addr[1:0]);
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = req_wdata;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            state_d   = ST_DONE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end else if (req_op == OP_SW) begin
            state_d   = ST_WR;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
          end else begin
            state_d   = ST_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end
      ST_RD: begin
        if (mem.mem_ack) begin
          if (is_store(op_q)) begin
            mem_wdata_d = merged_word;
            mem_we_d    = 1'b1;
            state_d     = ST_WR;
          end else begin
            rdata_d   = load_data;
            mem_req_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_WR: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      addr_lo_q   <= 2'b00;
      pc_q        <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      pc_q        <= pc_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign stall      = ((state_q == ST_IDLE) && req_valid) ||
                      (state_q == ST_RD) || (state_q == ST_WR);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign addr_err   = (state_q == ST_DONE) && err_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

`ifdef LSU_DISPLAY_EN
  // Trace every completed write with the PC of the instruction that issued it.
  always @(posedge clk) begin
    if (reset && (state_q == ST_WR) && mem.mem_ack)
      $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr_q, mem_wdata_q);
  end
`else
  // The PC only feeds the write trace.
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed scoreboard bench for lsu_master. Stimulus pushes
// expected responses and writes; monitors pop and compare when the DUT
// presents them.
module tb_lsu_master;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;

  lsu_master_if mif ();

  lsu_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .addr_err   (addr_err),
    .mem        (mif)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  resp_t       exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem_model [0:15];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        force_ack = 1'b0;
  logic [31:0] pc_cnt    = 32'h0000_1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks a request once it has waited ack_delay cycles,
  // checks every completed write against the expected write queue.
  always @(negedge clk) begin
    wr_t w;
    if (force_ack) begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = mem_model[0];
    end else if (!mif.mem_req) begin
      mif.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (wait_cnt >= ack_delay) begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = mem_model[mif.mem_addr[5:2]];
      wait_cnt      = 0;
      if (mif.mem_we) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", mif.mem_addr, w.addr);
          check("wr_data", mif.mem_wdata, w.data);
        end
        mem_model[mif.mem_addr[5:2]] = mif.mem_wdata;
      end
    end else begin
      mif.mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Response monitor: every resp_valid pulse must match the next expectation.
  always @(negedge clk) begin
    resp_t e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_addr_err", 32'(addr_err), 32'(e.err));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_stall"},      32'(stall),      32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    check({tag, "_addr_err"},   32'(addr_err),   32'd0);
    check({tag, "_mem_req"},    32'(mif.mem_req), 32'd0);
    check({tag, "_mem_we"},     32'(mif.mem_we),  32'd0);
    check({tag, "_mem_addr"},   mif.mem_addr,    32'd0);
    check({tag, "_mem_wdata"},  mif.mem_wdata,   32'd0);
  endtask

  // Issue one request, hold it while stalled, and measure latency, stall
  // cycles and request cycles. Cycle 1 is the accept cycle.
  task automatic do_req(input string name, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_stall);
    int          lat;
    int          stalls;
    int          req_cycles;
    logic [31:0] word_addr;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    word_addr = {addr[31:2], 2'b00};
    lat = 0;
    stalls = 0;
    req_cycles = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc_cnt;
    pc_cnt    = pc_cnt + 32'd4;
    for (int c = 1; c <= 64; c++) begin
      #1;
      if (stall) stalls++;
      if (mif.mem_req) begin
        req_cycles++;
        check({name, "_mem_addr"}, mif.mem_addr, word_addr);
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, "_req_cycles"}, 32'(req_cycles), exp_err ? 32'd0 : 32'(exp_lat - 2));
  endtask

  initial begin
    int n_resp;
    int n_req;
    reset         = 1'b0;
    req_valid     = 1'b0;
    req_op        = OP_LW;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    req_pc        = 32'h0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;

    #12;
    check_reset_values("por");
    @(negedge clk);
    #1 reset = 1'b1;

    // Full-word store.
    wr_q.push_back('{addr: 32'h10, data: 32'hDEADBEEF});
    do_req("sw", OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 2);

    // Read-modify-write byte and halfword stores into the same word.
    mem_model[4] = 32'h11223344;
    wr_q.push_back('{addr: 32'h10, data: 32'h11AA3344});
    do_req("sb", OP_SB, 32'h12, 32'h000000AA, 32'h0, 1'b0, 4, 3);
    wr_q.push_back('{addr: 32'h10, data: 32'hBEEF3344});
    do_req("sh", OP_SH, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 4, 3);

    // Loads from word 0x80FF7F01: extension and lane selection.
    mem_model[0] = 32'h80FF7F01;
    do_req("lb2",  OP_LB,  32'h2, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 2);
    do_req("lbu2", OP_LBU, 32'h2, 32'h0, 32'h000000FF, 1'b0, 3, 2);
    do_req("lh2",  OP_LH,  32'h2, 32'h0, 32'hFFFF80FF, 1'b0, 3, 2);
    do_req("lhu0", OP_LHU, 32'h0, 32'h0, 32'h00007F01, 1'b0, 3, 2);
    do_req("lw0",  OP_LW,  32'h0, 32'h0, 32'h80FF7F01, 1'b0, 3, 2);
    do_req("lb1",  OP_LB,  32'h1, 32'h0, 32'h0000007F, 1'b0, 3, 2);
    do_req("lbu3", OP_LBU, 32'h3, 32'h0, 32'h00000080, 1'b0, 3, 2);
    do_req("lhu2", OP_LHU, 32'h2, 32'h0, 32'h000080FF, 1'b0, 3, 2);
    do_req("lh0",  OP_LH,  32'h0, 32'h0, 32'h00007F01, 1'b0, 3, 2);

    // Misaligned accesses never reach the memory.
    do_req("lw6_err",  OP_LW, 32'h6,  32'h0, 32'h0, 1'b1, 2, 1);
    do_req("sh3_err",  OP_SH, 32'h3,  32'h0, 32'h0, 1'b1, 2, 1);
    do_req("sw11_err", OP_SW, 32'h11, 32'h5A5A5A5A, 32'h0, 1'b1, 2, 1);

    // Slow memory: ack arrives in the 4th request cycle.
    mem_model[8] = 32'hCAFEF00D;
    ack_delay = 3;
    do_req("lw_slow", OP_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 6, 5);
    ack_delay = 0;

    // Reset in the middle of a read, then a stray ack after release.
    ack_delay = 20;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_LW;
    req_addr  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_pre_mem_req", 32'(mif.mem_req), 32'd1);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    #1;
    reset     = 1'b1;
    force_ack = 1'b1;
    n_resp = 0;
    n_req  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (c == 2) force_ack = 1'b0;
      if (resp_valid) n_resp++;
      if (mif.mem_req) n_req++;
    end
    check("rst_late_ack_resp", 32'(n_resp), 32'd0);
    check("rst_late_ack_req", 32'(n_req), 32'd0);
    ack_delay = 0;

    // Normal operation resumes after reset.
    do_req("lw_after_rst", OP_LW, 32'h0, 32'h0, 32'h80FF7F01, 1'b0, 3, 2);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
